// File: rtl/alu_result_buffer.sv
// Result FIFO between the ALU and its consumer. A registered output stage holds
// the head entry, and the buffer keeps sticky carry/overflow/illegal-op flags.
module alu_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_result,
  input  logic [15:0] in_rem,
  input  logic [3:0]  in_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [31:0] out_result,
  output logic [15:0] out_rem,
  output logic [3:0]  out_flags,
  input  logic        sticky_clr,
  output logic        sticky_c,
  output logic        sticky_v,
  output logic        sticky_err,
  output logic [15:0] op_count,
  output logic [4:0]  level
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         EW       = 56;
  localparam logic [4:0] LVL_FULL = 5'(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [4:0]    r_level;
  logic          r_init;
  logic [EW-1:0] r_out;
  logic          r_sticky_c;
  logic          r_sticky_v;
  logic          r_sticky_err;
  logic [15:0]   r_op_count;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [4:0]    w_level_nxt;
  logic [EW-1:0] w_in_entry;
  logic [EW-1:0] w_head_nxt;
  logic          w_arith;
  logic          w_set_c;
  logic          w_set_v;
  logic          w_set_err;

  // r_init keeps in_ready low until the first edge after reset release
  assign in_ready   = r_init && (r_level != LVL_FULL);
  assign out_valid  = (r_level != 5'd0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  assign w_in_entry = {in_op, in_result, in_rem, in_flags};

  assign {out_op, out_result, out_rem, out_flags} = r_out;
  assign sticky_c   = r_sticky_c;
  assign sticky_v   = r_sticky_v;
  assign sticky_err = r_sticky_err;
  assign op_count   = r_op_count;
  assign level      = r_level;

  // Next pointers, occupancy, and the entry that becomes head after this edge
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    w_head_nxt   = r_mem[r_rd_ptr];
    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 5'd1;
      2'b01:   w_level_nxt = r_level - 5'd1;
      default: w_level_nxt = r_level;
    endcase
    // The slot being written this edge is not in r_mem yet, so forward it
    if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_head_nxt = w_in_entry;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Sticky flag set conditions for the entry being accepted
  always_comb begin
    w_arith   = (in_op == 4'b0000) || (in_op == 4'b0001);
    w_set_c   = 1'b0;
    w_set_v   = 1'b0;
    w_set_err = 1'b0;
    if (w_push) begin
      w_set_c   = w_arith && in_flags[1];
      w_set_v   = w_arith && in_flags[0];
      w_set_err = (in_op >= 4'b1100);
    end else begin
      w_set_c   = 1'b0;
      w_set_v   = 1'b0;
      w_set_err = 1'b0;
    end
  end

  // Entry storage; stale contents are unreachable because pointers reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // Control state, output stage, sticky flags and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= 5'd0;
      r_init       <= 1'b0;
      r_out        <= '0;
      r_sticky_c   <= 1'b0;
      r_sticky_v   <= 1'b0;
      r_sticky_err <= 1'b0;
      r_op_count   <= 16'd0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_level      <= w_level_nxt;
      r_init       <= 1'b1;
      if (w_level_nxt != 5'd0) begin
        r_out <= w_head_nxt;
      end
      r_sticky_c   <= w_set_c   || (r_sticky_c   && !sticky_clr);
      r_sticky_v   <= w_set_v   || (r_sticky_v   && !sticky_clr);
      r_sticky_err <= w_set_err || (r_sticky_err && !sticky_clr);
      if (w_push && (r_op_count != 16'hFFFF)) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: a reference model with a
// scoreboard queue, a sticky-flag vector table, and hand-written corner cases.
module tb_alu_result_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_result;
  logic [15:0] in_rem;
  logic [3:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_result;
  logic [15:0] out_rem;
  logic [3:0]  out_flags;
  logic        sticky_clr;
  logic        sticky_c;
  logic        sticky_v;
  logic        sticky_err;
  logic [15:0] op_count;
  logic [4:0]  level;

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_result(in_result), .in_rem(in_rem), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_result(out_result), .out_rem(out_rem), .out_flags(out_flags),
    .sticky_clr(sticky_clr), .sticky_c(sticky_c), .sticky_v(sticky_v),
    .sticky_err(sticky_err), .op_count(op_count), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] res;
    logic [15:0] rem;
    logic [3:0]  flags;
    logic        clr;
    logic [2:0]  exp_sticky;
  } vec_t;

  vec_t        vecs [9];
  logic [55:0] q[$];
  int          mlevel;
  bit          minit;
  bit          msc, msv, mse;
  logic [15:0] mcount;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mlevel = 0;
    minit  = 1'b0;
    msc    = 1'b0;
    msv    = 1'b0;
    mse    = 1'b0;
    mcount = 16'd0;
  endtask

  // Check current state against the model, then advance model and DUT one edge
  task automatic cycle();
    bit push, pop, arith;
    chk("level", level, mlevel);
    chk("in_ready", in_ready, minit && (mlevel != DEPTH));
    chk("out_valid", out_valid, mlevel != 0);
    if (mlevel != 0) chk("out_entry", {out_op, out_result, out_rem, out_flags}, q[0]);
    chk("sticky", {sticky_c, sticky_v, sticky_err}, {msc, msv, mse});
    chk("op_count", op_count, mcount);
    push  = in_valid && minit && (mlevel != DEPTH);
    pop   = out_ready && (mlevel != 0);
    arith = (in_op == 4'b0000) || (in_op == 4'b0001);
    if (pop) void'(q.pop_front());
    if (push) q.push_back({in_op, in_result, in_rem, in_flags});
    msc = (push && arith && in_flags[1]) || (msc && !sticky_clr);
    msv = (push && arith && in_flags[0]) || (msv && !sticky_clr);
    mse = (push && (in_op >= 4'b1100)) || (mse && !sticky_clr);
    if (push && mcount != 16'hFFFF) mcount = mcount + 16'd1;
    mlevel = mlevel + int'(push) - int'(pop);
    minit  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_wait(input logic [3:0] op, input logic [31:0] res,
                           input logic [15:0] rem, input logic [3:0] flags);
    bit accepted = 1'b0;
    in_valid  = 1'b1;
    in_op     = op;
    in_result = res;
    in_rem    = rem;
    in_flags  = flags;
    for (int n = 0; n < 8 && !accepted; n++) begin
      accepted = minit && (mlevel != DEPTH);
      cycle();
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: entry %0h not accepted within 8 cycles", res);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && mlevel != 0; n++) cycle();
    cycle();
    chk("drain_level", level, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{4'h1, 32'h1111_0001, 16'h0001, 4'b0001, 1'b0, 3'b010};
    vecs[1] = '{4'hD, 32'hDEAD_BEEF, 16'hBEEF, 4'b0000, 1'b0, 3'b011};
    vecs[2] = '{4'h0, 32'h0000_0002, 16'h0002, 4'b0010, 1'b1, 3'b100};
    vecs[3] = '{4'h2, 32'hFFFF_FFFF, 16'h8000, 4'b1111, 1'b0, 3'b100};
    vecs[4] = '{4'h0, 32'h8000_0000, 16'hFFFF, 4'b0001, 1'b0, 3'b110};
    vecs[5] = '{4'hB, 32'h0BAD_F00D, 16'h1234, 4'b0000, 1'b1, 3'b000};
    vecs[6] = '{4'hC, 32'hC0C0_C0C0, 16'h0C0C, 4'b0000, 1'b0, 3'b001};
    vecs[7] = '{4'hF, 32'h7FFF_FFFF, 16'h7FFF, 4'b0011, 1'b0, 3'b001};
    vecs[8] = '{4'h1, 32'h0000_0008, 16'h0008, 4'b0010, 1'b1, 3'b100};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
    in_op = 4'd0; in_result = 32'd0; in_rem = 16'd0; in_flags = 4'd0;
    model_reset();
    #2;
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", {out_op, out_result, out_rem, out_flags}, 0);
    chk("rst_sticky", {sticky_c, sticky_v, sticky_err}, 0);
    chk("rst_op_count", op_count, 0);
    #6;
    rst_n = 1'b1;
    cycle();
    chk("in_ready_after_release", in_ready, 1);

    // Single pass
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'h0; in_result = 32'h0000_0005; in_rem = 16'h0; in_flags = 4'h0;
    cycle();
    in_valid = 1'b0;
    chk("single_out_result", out_result, 32'h0000_0005);
    chk("single_out_valid", out_valid, 1);
    cycle();
    chk("single_level", level, 0);
    chk("single_op_count", op_count, 1);

    // Sticky vector table, streamed back-to-back
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_op = vecs[i].op; in_result = vecs[i].res; in_rem = vecs[i].rem; in_flags = vecs[i].flags;
      sticky_clr = vecs[i].clr;
      cycle();
      sticky_clr = 1'b0;
      chk($sformatf("vec%0d_sticky", i), {sticky_c, sticky_v, sticky_err}, vecs[i].exp_sticky);
    end
    drain();

    // Fill and stall, then full with simultaneous pop
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_wait(4'h2, 32'(i), 16'(i), 4'h0);
    in_valid = 1'b1; in_result = 32'h5; in_rem = 16'h5;
    cycle();
    cycle();
    chk("full_level", level, 4);
    chk("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    cycle();
    chk("full_pop_level", level, 3);
    chk("full_pop_in_ready", in_ready, 1);
    cycle();
    drain();

    // Back-to-back push/pop across pointer wrap up to counter saturation
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      logic [31:0] v;
      v = 32'(i);
      in_op = v[3:0]; in_result = v * 32'd3 + 32'd7; in_rem = v[15:0]; in_flags = v[7:4];
      cycle();
    end
    drain();
    chk("op_count_sat", op_count, 16'hFFFF);

    // Asynchronous reset with three entries stored
    sticky_clr = 1'b1;
    cycle();
    sticky_clr = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_wait(4'h1, 32'hA000_0000 + 32'(i), 16'h0, 4'b0011);
    chk("pre_reset_level", level, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_level", level, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_out_data", {out_op, out_result, out_rem, out_flags}, 0);
    chk("async_sticky", {sticky_c, sticky_v, sticky_err}, 0);
    chk("async_op_count", op_count, 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    cycle();
    out_ready = 1'b1;
    push_wait(4'h3, 32'h0000_ABCD, 16'h00CD, 4'b1000);
    chk("post_reset_result", out_result, 32'h0000_ABCD);
    drain();
    chk("post_reset_op_count", op_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the FIFO entry count; legal values are powers of two, 2 to 16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous and active-low.
REQ-004 in_valid  input  1  SHALL indicate that ALU outputs on in_* are valid this cycle.
REQ-005 in_ready  output  1  SHALL indicate that the buffer can accept an entry (not full).
REQ-006 in_op  input  4  SHALL carry the ALU operation code for this result.
REQ-007 in_result  input  32  SHALL carry the ALU Result.
REQ-008 in_rem  input  16  SHALL carry the ALU Remainder.
REQ-009 in_flags  input  4  SHALL carry {Z,N,C,V}, MSB first.
REQ-010 out_valid  output  1  SHALL indicate that the head entry is presented on out_*.
REQ-011 out_ready  input  1  SHALL indicate that the consumer accepts the head entry.
REQ-012 out_op/out_result/out_rem/out_flags  output  4/32/16/4  SHALL present the head entry fields.
REQ-013 sticky_clr  input  1  SHALL be a single-cycle clear request for the sticky flags.
REQ-014 sticky_c, sticky_v, sticky_err  output  1 each  SHALL be the sticky carry, overflow and illegal-op flags.
REQ-015 op_count  output  16  SHALL count accepted entries.
REQ-016 level  output  5  SHALL report the current occupancy, 0 to DEPTH.

Function
REQ-017 Push SHALL occur only when in_valid && in_ready; pop SHALL occur only when out_valid && out_ready.
REQ-018 in_ready SHALL be (level != DEPTH), out_valid SHALL be (level != 0), and both SHALL be derived from registered state only.
REQ-019 No bypass: an entry pushed at edge k SHALL first appear on out_* with out_valid=1 after edge k, never in the same cycle.
REQ-020 Storage SHALL be a circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-021 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and advance both pointers.
REQ-022 When full, in_ready=0 SHALL block the push even if a pop occurs in the same cycle; in_ready rises the cycle after the pop.
REQ-023 When empty, out_* data SHALL hold the last-presented values (or reset values) and the consumer SHALL ignore them.
REQ-024 On each push: sticky_c SHALL be set if in_flags[1]=1 and in_op is 0000 or 0001; sticky_v SHALL be set if in_flags[0]=1 and in_op is 0000 or 0001; sticky_err SHALL be set if in_op >= 1100.
REQ-025 Entries with an illegal op SHALL still be stored and delivered unchanged.
REQ-026 sticky_clr SHALL clear all sticky flags at the next edge, except that a set condition in the same cycle wins (flag = 1).
REQ-027 op_count SHALL increment by 1 per push and saturate at 0xFFFF; it SHALL be cleared only by reset.
REQ-028 Payload SHALL be stored bit-exact; no sign extension or modification.

Reset
REQ-029 rst_n=0 SHALL immediately force level=0, pointers=0, out_valid=0, in_ready=0, out_* data=0, sticky_*=0, and op_count=0.
REQ-030 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-031 Reset during operation SHALL discard all stored entries; no entry pushed before reset SHALL appear afterwards.

Verification
REQ-032 Single pass: push op=0000, result=0x00000005, flags=0000 at edge 1 with out_ready=1 -> out_valid=1 with result 0x00000005 after edge 1, level=0 after edge 2, op_count=1.
REQ-033 Fill and stall: DEPTH=4, out_ready=0, push 5 entries 0x1..0x5 -> in_ready=0 after the 4th push, 5th held off, level=4; then out_ready=1 -> outputs 0x1,0x2,0x3,0x4, then 0x5, in order.
REQ-034 Full with simultaneous pop: level=4, in_valid=1, out_ready=1 -> no push that cycle, level=3, in_ready=1 next cycle.
REQ-035 Sticky: push op=0001, flags=0001 -> sticky_v=1; push op=1101 -> sticky_err=1; sticky_clr together with a push of op=0000, flags=0010 -> sticky_c=1 and sticky_v=0, sticky_err=0.
REQ-036 Wrap and saturate: 70000 back-to-back push/pop pairs -> data order preserved across pointer wrap, op_count=0xFFFF.
REQ-037 Async reset: assert rst_n=0 mid-cycle with level=3 -> out_valid=0 and level=0 without waiting for a clock edge; no stale entry appears after release.
